// File: rtl/memory_map.sv
// Hack data-memory map: RAM, keyboard register, screen-write FIFO; SCREEN_SHADOW_EN adds a readable screen shadow.
// Reads are registered (1 cycle, read-first); screen writes are dropped when the FIFO is full and nothing pops that cycle.
module memory_map #(
   parameter int RAM_WORDS  = 16384,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] mem_address,
   input  logic        mem_write,
   input  logic [15:0] mem_wdata,
   output logic [15:0] mem_rdata,
   input  logic        kbd_valid,
   input  logic [15:0] kbd_code,
   output logic        scr_valid,
   input  logic        scr_ready,
   output logic [12:0] scr_addr,
   output logic [15:0] scr_data,
   output logic        scr_overflow
);
   localparam int RAM_AW = $clog2(RAM_WORDS);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

   logic              w_is_ram;
   logic              w_is_scr;
   logic              w_is_kbd;
   logic [RAM_AW-1:0] w_ram_idx;
   logic              w_ram_we;
   logic              w_scr_we;
   logic [15:0]       w_scr_rd;

   assign w_is_ram  = (mem_address[15:14] == 2'b00);
   assign w_is_scr  = (mem_address[15:13] == 3'b010);
   assign w_is_kbd  = (mem_address == 16'h6000);
   assign w_ram_idx = mem_address[RAM_AW-1:0];
   assign w_ram_we  = mem_write && w_is_ram && !reset;
   assign w_scr_we  = mem_write && w_is_scr && !reset;

   logic [15:0] r_ram [RAM_WORDS];
   logic [15:0] r_kbd;
   logic [15:0] r_rdata;

   always_ff @(posedge clk) begin
      if (w_ram_we)
         r_ram[w_ram_idx] <= mem_wdata;
   end

`ifdef SCREEN_SHADOW_EN
   logic [15:0] r_shadow [8192];

   // Shadow sees every screen write, including those the FIFO drops.
   always_ff @(posedge clk) begin
      if (w_scr_we)
         r_shadow[mem_address[12:0]] <= mem_wdata;
   end
   assign w_scr_rd = r_shadow[mem_address[12:0]];
`else
   assign w_scr_rd = 16'h0000;
`endif

   always_ff @(posedge clk) begin
      if (reset)
         r_kbd <= 16'h0000;
      else if (kbd_valid)
         r_kbd <= kbd_code;
   end

   // Array reads here see pre-edge contents, giving read-first behaviour.
   always_ff @(posedge clk) begin
      if (reset)
         r_rdata <= 16'h0000;
      else if (w_is_ram)
         r_rdata <= r_ram[w_ram_idx];
      else if (w_is_scr)
         r_rdata <= w_scr_rd;
      else if (w_is_kbd)
         r_rdata <= r_kbd;
      else
         r_rdata <= 16'h0000;
   end

   assign mem_rdata = r_rdata;

   logic [12:0]      r_fifo_addr [FIFO_DEPTH];
   logic [15:0]      r_fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;
   logic             w_full;
   logic             w_pop;
   logic             w_push_ok;
   logic             w_drop;

   assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_pop     = (r_count != '0) && scr_ready;
   assign w_push_ok = w_scr_we && (!w_full || w_pop);
   assign w_drop    = w_scr_we && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_fifo_addr[r_wr_ptr] <= mem_address[12:0];
         r_fifo_data[r_wr_ptr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push_ok && !w_pop)
            r_count <= r_count + CNT_W'(1);
         else if (!w_push_ok && w_pop)
            r_count <= r_count - CNT_W'(1);
         if (w_drop)
            r_overflow <= 1'b1;
      end
   end

   assign scr_valid    = (r_count != '0);
   assign scr_addr     = r_fifo_addr[r_rd_ptr];
   assign scr_data     = r_fifo_data[r_rd_ptr];
   assign scr_overflow = r_overflow;

endmodule

// File: tb/tb_memory_map.sv
// Directed bench for memory_map: RAM, keyboard, screen FIFO, overflow, reset and shadow reads.
module tb_memory_map;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] mem_address;
   logic        mem_write;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        kbd_valid;
   logic [15:0] kbd_code;
   logic        scr_valid;
   logic        scr_ready;
   logic [12:0] scr_addr;
   logic [15:0] scr_data;
   logic        scr_overflow;

   int n_chk  = 0;
   int n_fail = 0;

   memory_map #(.RAM_WORDS(16384), .FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_address  (mem_address),
      .mem_write    (mem_write),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .kbd_valid    (kbd_valid),
      .kbd_code     (kbd_code),
      .scr_valid    (scr_valid),
      .scr_ready    (scr_ready),
      .scr_addr     (scr_addr),
      .scr_data     (scr_data),
      .scr_overflow (scr_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the rising edge they result from.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      mem_address = a;
      mem_wdata   = d;
      mem_write   = 1'b1;
      step();
      mem_write   = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a);
      mem_address = a;
      mem_write   = 1'b0;
      step();
   endtask

   logic [15:0] shadow_exp;

   initial begin
      reset = 1'b1; mem_address = 16'h0000; mem_write = 1'b0; mem_wdata = 16'h0000;
      kbd_valid = 1'b0; kbd_code = 16'h0000; scr_ready = 1'b0;
      step(); step();
      reset = 1'b0;
      chk("rst_rdata", {16'h0, mem_rdata}, 32'h0);
      chk("rst_scr_valid", {31'h0, scr_valid}, 32'h0);
      chk("rst_overflow", {31'h0, scr_overflow}, 32'h0);

      // RAM write then read, then read-during-write returns old word
      wr(16'h0005, 16'h1234);
      rd(16'h0005);
      chk("ram_read", {16'h0, mem_rdata}, 32'h1234);
      wr(16'h0005, 16'hBEEF);
      chk("ram_read_first", {16'h0, mem_rdata}, 32'h1234);
      rd(16'h0005);
      chk("ram_new_word", {16'h0, mem_rdata}, 32'hBEEF);

      // Keyboard register
      mem_address = 16'h6000; kbd_valid = 1'b1; kbd_code = 16'h0083;
      step();
      kbd_valid = 1'b0;
      chk("kbd_pre_update", {16'h0, mem_rdata}, 32'h0000);
      rd(16'h6000);
      chk("kbd_code", {16'h0, mem_rdata}, 32'h0083);
      kbd_valid = 1'b1; kbd_code = 16'h0000;
      step();
      kbd_valid = 1'b0;
      rd(16'h6000);
      chk("kbd_release", {16'h0, mem_rdata}, 32'h0000);
      kbd_valid = 1'b1; kbd_code = 16'h0041;
      step();
      kbd_valid = 1'b0;
      wr(16'h6000, 16'hFFFF);
      rd(16'h6000);
      chk("kbd_write_ignored", {16'h0, mem_rdata}, 32'h0041);
      rd(16'h7000);
      chk("unmapped_7000", {16'h0, mem_rdata}, 32'h0000);
      rd(16'h6001);
      chk("unmapped_6001", {16'h0, mem_rdata}, 32'h0000);

      // Screen FIFO handshake
      scr_ready = 1'b0;
      wr(16'h4000, 16'hAAAA);
      chk("scr_valid_next_cycle", {31'h0, scr_valid}, 32'h1);
      wr(16'h5FFF, 16'h5555);
      step();
      chk("scr_hold_valid", {31'h0, scr_valid}, 32'h1);
      chk("scr_hold_addr", {19'h0, scr_addr}, 32'h0000);
      chk("scr_hold_data", {16'h0, scr_data}, 32'hAAAA);
      scr_ready = 1'b1;
      step();
      chk("scr_second_addr", {19'h0, scr_addr}, 32'h1FFF);
      chk("scr_second_data", {16'h0, scr_data}, 32'h5555);
      step();
      chk("scr_drained", {31'h0, scr_valid}, 32'h0);

      // Shadow read of a screen address
`ifdef SCREEN_SHADOW_EN
      shadow_exp = 16'h00FF;
`else
      shadow_exp = 16'h0000;
`endif
      wr(16'h4010, 16'h00FF);
      chk("shadow_push_addr", {19'h0, scr_addr}, 32'h0010);
      chk("shadow_push_data", {16'h0, scr_data}, 32'h00FF);
      rd(16'h4010);
      chk("shadow_read", {16'h0, mem_rdata}, {16'h0, shadow_exp});
      chk("shadow_popped", {31'h0, scr_valid}, 32'h0);

      // Overflow: five writes into a four-entry FIFO
      scr_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         wr(16'h4100 + 16'(i), 16'h1000 + 16'(i));
      chk("full_no_overflow", {31'h0, scr_overflow}, 32'h0);
      wr(16'h4104, 16'h1004);
      chk("overflow_set", {31'h0, scr_overflow}, 32'h1);
      scr_ready = 1'b1;
      chk("full_head_data", {16'h0, scr_data}, 32'h1000);
      wr(16'h4200, 16'h2222);
      for (int i = 1; i < 4; i++) begin
         chk("drain_addr", {19'h0, scr_addr}, 32'h0100 + i);
         chk("drain_data", {16'h0, scr_data}, 32'h1000 + i);
         step();
      end
      chk("pushpop_addr", {19'h0, scr_addr}, 32'h0200);
      chk("pushpop_data", {16'h0, scr_data}, 32'h2222);
      step();
      chk("overflow_drained", {31'h0, scr_valid}, 32'h0);
      chk("overflow_sticky", {31'h0, scr_overflow}, 32'h1);

      // Reset mid-operation
      scr_ready = 1'b0;
      kbd_valid = 1'b1; kbd_code = 16'h0041;
      step();
      kbd_valid = 1'b0;
      for (int i = 0; i < 3; i++)
         wr(16'h4300 + 16'(i), 16'h3000 + 16'(i));
      rd(16'h6000);
      rd(16'h6000);
      chk("pre_reset_kbd", {16'h0, mem_rdata}, 32'h0041);
      chk("pre_reset_valid", {31'h0, scr_valid}, 32'h1);
      reset = 1'b1; mem_address = 16'h0005; mem_wdata = 16'hDEAD; mem_write = 1'b1;
      step();
      reset = 1'b0; mem_write = 1'b0;
      chk("reset_scr_valid", {31'h0, scr_valid}, 32'h0);
      chk("reset_rdata", {16'h0, mem_rdata}, 32'h0000);
      chk("reset_overflow", {31'h0, scr_overflow}, 32'h0);
      rd(16'h6000);
      chk("reset_kbd", {16'h0, mem_rdata}, 32'h0000);
      rd(16'h0005);
      chk("ram_survives_reset", {16'h0, mem_rdata}, 32'hBEEF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
